imem_boot_ctrl: RTL
===================

Name: imem_boot_ctrl

Overview:
Boot-load sequencer and port arbiter for the single-cycle MIPS instruction memory.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
- Writes each word into the synchronous-write port of the 64-word instruction memory.
- Holds the CPU stalled during the load, then hands the memory address port to the CPU fetch path.
- Sits between the top-level boot interface, the instruction memory and the processor's run/stall input.

Parameters:
ADDR_W, 6, word-address width of instruction memory
WORDS, 64, memory depth in words (2**ADDR_W)

Ports:
clk  in  1  system clock, all state on rising edge
reset_n  in  1  synchronous active-low reset
load_start  in  1  pulse: begin (or restart) a load
load_len  in  ADDR_W+1  number of words to load, sampled on load_start, 0..WORDS
byte_valid  in  1  source has a byte
byte_data  in  8  byte payload
byte_ready  out  1  controller accepts byte this cycle
cpu_addr  in  ADDR_W  CPU fetch word address (PC[7:2])
mem_addr  out  ADDR_W  address to instruction memory
mem_we  out  1  instruction memory write enable
mem_wdata  out  32  instruction memory write data
cpu_run  out  1  1 = CPU may execute; 0 = CPU stalled
load_done  out  1  one-cycle pulse when the last word is written
words_written  out  ADDR_W+1  words written in the current or last load

Behaviour:
- Clock and reset
  - Single clock `clk`.
  - Reset is synchronous, active-low on `reset_n`; it has priority over all other inputs.
  - Reset values: state=IDLE, byte_ready=0, mem_we=0, mem_wdata=0, load_done=0, cpu_run=0, words_written=0, byte_cnt=0, word_ptr=0.
- FSM states: IDLE, LOAD, WRITE, RUN.
- IDLE
  - cpu_run=0, byte_ready=0.
  - load_start -> LOAD; latch load_len, clear word_ptr, byte_cnt and words_written.
- LOAD
  - byte_ready=1.
  - A byte is accepted on byte_valid&byte_ready: word_buf = {word_buf[23:0], byte_data} (first byte lands in [31:24]), and byte_cnt++.
  - On acceptance of the 4th byte (byte_cnt==3) -> WRITE next cycle; byte_cnt wraps to 0.
- WRITE (exactly one cycle)
  - byte_ready=0, mem_we=1, mem_addr=word_ptr, mem_wdata=word_buf.
  - word_ptr++ and words_written++.
  - If words_written+1==latched_len: -> RUN with load_done=1 for that transition cycle.
  - Otherwise -> LOAD.
- RUN
  - cpu_run=1, mem_we=0, byte_ready=0.
  - load_start -> LOAD; cpu_run drops the next cycle.
- mem_addr mux: cpu_addr in RUN; word_ptr in all other states.
- Load-length boundaries
  - load_len==0 on load_start: go directly to RUN, load_done pulses, no writes.
  - load_len>WORDS: clamp to WORDS.
  - word_ptr wraps 63->0 only through clamping, so it never rewrites within one load.
- load_start during LOAD or WRITE: restart.
  - Any partial word is discarded.
  - A WRITE in progress still completes its single write.
  - Counters clear next cycle.
- Bytes presented while byte_ready=0 are not consumed; the source must hold them.
- Reset mid-load: immediate return to IDLE, cpu_run=0, memory contents left as written.
- Latency: load_done is asserted 1 cycle after the final byte handshake.
- Throughput: 5 cycles per word at full byte rate.

Optional Feature:
IMEM_BOOT_CHECKSUM_EN
- With the macro: adds output `checksum[31:0]`.
  - Running XOR of every written word.
  - Cleared on reset and on load_start; updated in WRITE.
  - Valid when load_done pulses.
- Without the macro: no port and no logic; behaviour is otherwise identical.

Decomposition:
- Package `imem_boot_pkg`:
  - typedef enum logic [1:0] boot_state_t {IDLE, LOAD, WRITE, RUN}.
  - Constants BYTES_PER_WORD=4 and IMEM_WORDS=64.
- Sub-module `byte_word_packer`: byte shift register plus 2-bit byte counter, with a word_valid pulse on the 4th byte.
- FSM, address mux and counters remain in the top.

Test Plan:
- reset_n=0 for 2 cycles, then 1 -> cpu_run=0, byte_ready=0, mem_we=0, state IDLE.
- load_start with load_len=2; bytes 20,08,00,05,AC,08,00,3C with no stalls -> mem_we at addr 0 with 0x20080005, then at addr 1 with 0xAC08003C; load_done 1 cycle after the last byte; cpu_run=1; mem_addr tracks cpu_addr=0x05.
- Same stream with byte_valid toggling every other cycle -> identical writes; no byte dropped or duplicated; words_written=2.
- load_start mid-word after 2 bytes, then 4 bytes 11,22,33,44 with load_len=1 -> a single write of 0x11223344 at addr 0; old partial bytes discarded.
- load_len=0 -> RUN with load_done pulse, zero writes; load_len=70 -> exactly 64 writes, addrs 0..63.
- reset_n low during the 3rd word -> IDLE next cycle, cpu_run=0; with IMEM_BOOT_CHECKSUM_EN, checksum for the two-word load = 0x20080005^0xAC08003C=0x8C000039.

Source files
------------

// File: rtl/imem_boot_ctrl_pkg.sv
// Shared types and constants for the instruction-memory boot controller.
package imem_boot_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int IMEM_WORDS     = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    RUN   = 2'd3
  } boot_state_t;

endpackage

// File: rtl/imem_boot_ctrl_if.sv
// Byte-stream boot interface: the source drives valid/data, the controller drives ready.
interface imem_boot_ctrl_if;

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       byte_ready;

  modport master (output byte_valid, output byte_data, input byte_ready);
  modport slave  (input byte_valid, input byte_data, output byte_ready);

endinterface

// File: rtl/imem_boot_ctrl_byte_word_packer.sv
// Assembles four accepted bytes into a big-endian word; word_valid_o marks the 4th byte.
module byte_word_packer
  import imem_boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clr_i,
  input  logic        accept_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_next_o,
  output logic        word_valid_o
);

  localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  // Only the three older bytes need storage; the 4th is taken straight from the input.
  logic [23:0] buf_q, buf_d;
  logic [1:0]  cnt_q, cnt_d;

  assign word_next_o  = {buf_q, byte_i};
  assign word_valid_o = accept_i && (cnt_q == LAST_BYTE);

  // Next shift-register and byte-count values.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    if (clr_i) begin
      buf_d = 24'h0;
      cnt_d = 2'd0;
    end else if (accept_i) begin
      buf_d = word_next_o[23:0];
      cnt_d = cnt_q + 2'd1;
    end else begin
      buf_d = buf_q;
      cnt_d = cnt_q;
    end
  end

  // Packer state registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      buf_q <= 24'h0;
      cnt_q <= 2'd0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/imem_boot_ctrl.sv
// Boot-load sequencer and instruction-memory port arbiter.
// Optional: define IMEM_BOOT_CHECKSUM_EN to add a running-XOR checksum output.
module imem_boot_ctrl
  import imem_boot_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int WORDS  = IMEM_WORDS
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  imem_boot_ctrl_if.slave   boot_if,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              load_done,
  output logic [ADDR_W:0]   words_written
`ifdef IMEM_BOOT_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_LOAD  = 2'(LOAD);
  localparam logic [1:0] ST_WRITE = 2'(WRITE);
  localparam logic [1:0] ST_RUN   = 2'(RUN);

  localparam logic [ADDR_W:0]   WORDS_L  = WORDS[ADDR_W:0];
  localparam logic [ADDR_W:0]   ONE_CNT  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ONE_PTR  = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   ww_q, ww_d;
  logic              byte_ready_q, byte_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              load_done_q, load_done_d;
  logic              cpu_run_q, cpu_run_d;

  logic [ADDR_W:0]   len_clamped_s;
  logic              last_word_s;
  logic              accept_s;
  logic              word_valid_s;
  logic [31:0]       word_next_s;

  assign accept_s      = boot_if.byte_valid && byte_ready_q;
  assign len_clamped_s = (load_len > WORDS_L) ? WORDS_L : load_len;
  assign last_word_s   = ((ww_q + ONE_CNT) == len_q);

  byte_word_packer u_packer (
    .clk          (clk),
    .reset_n      (reset_n),
    .clr_i        (load_start),
    .accept_i     (accept_s),
    .byte_i       (boot_if.byte_data),
    .word_next_o  (word_next_s),
    .word_valid_o (word_valid_s)
  );

  // FSM next state, counters and registered-output next values.
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    ptr_d       = ptr_q;
    ww_d        = ww_q;
    mem_wdata_d = mem_wdata_q;
    load_done_d = 1'b0;
    if (load_start) begin
      // A restart from any state wins; a write already on the bus still completes.
      len_d = len_clamped_s;
      ptr_d = {ADDR_W{1'b0}};
      ww_d  = {(ADDR_W+1){1'b0}};
      if (len_clamped_s == {(ADDR_W+1){1'b0}}) begin
        state_d     = ST_RUN;
        load_done_d = 1'b1;
      end else begin
        state_d = ST_LOAD;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_LOAD: begin
          if (word_valid_s) begin
            state_d     = ST_WRITE;
            mem_wdata_d = word_next_s;
            load_done_d = last_word_s;
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_WRITE: begin
          ptr_d   = ptr_q + ONE_PTR;
          ww_d    = ww_q + ONE_CNT;
          state_d = last_word_s ? ST_RUN : ST_LOAD;
        end
        ST_RUN:  state_d = ST_RUN;
        default: state_d = ST_IDLE;
      endcase
    end
    byte_ready_d = (state_d == ST_LOAD);
    mem_we_d     = (state_d == ST_WRITE);
    cpu_run_d    = (state_d == ST_RUN);
  end

  // Controller state and output registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      len_q        <= {(ADDR_W+1){1'b0}};
      ptr_q        <= {ADDR_W{1'b0}};
      ww_q         <= {(ADDR_W+1){1'b0}};
      byte_ready_q <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= 32'h0;
      load_done_q  <= 1'b0;
      cpu_run_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      ptr_q        <= ptr_d;
      ww_q         <= ww_d;
      byte_ready_q <= byte_ready_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      load_done_q  <= load_done_d;
      cpu_run_q    <= cpu_run_d;
    end
  end

  // Memory address port belongs to the CPU fetch path only while running.
  always_comb begin
    if (state_q == ST_RUN) begin
      mem_addr = cpu_addr;
    end else begin
      mem_addr = ptr_q;
    end
  end

  assign boot_if.byte_ready = byte_ready_q;
  assign mem_we             = mem_we_q;
  assign mem_wdata          = mem_wdata_q;
  assign cpu_run            = cpu_run_q;
  assign load_done          = load_done_q;
  assign words_written      = ww_q;

`ifdef IMEM_BOOT_CHECKSUM_EN
  logic [31:0] checksum_q, checksum_d;

  // Folded in as the word enters WRITE, so the sum is complete while load_done is high.
  always_comb begin
    if (load_start) begin
      checksum_d = 32'h0;
    end else if ((state_q == ST_LOAD) && word_valid_s) begin
      checksum_d = checksum_q ^ word_next_s;
    end else begin
      checksum_d = checksum_q;
    end
  end

  // Checksum register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      checksum_q <= 32'h0;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`endif

endmodule
